chase_flip_alpha_gen: RTL and testbench
=======================================

Name: chase_flip_alpha_gen

Overview:
- Streaming front end of the Chase test-pattern path, directly upstream of the flip-syndrome stage.
- Consumes one soft bit (LLR) per beat for a BCH codeword and finds the two least-reliable bit positions.
- For each position it produces alpha^p, alpha^3p, alpha^5p and alpha^7p in the selected GF(2^m).
- Its flip-alpha outputs and valid drive the flip-syndrome stage's flip-alpha inputs directly.

Parameters:
- LLR_W, 8, width of two's-complement input LLR.
- GF_W, 10, width of every field-element bus; element occupies bits [m-1:0], upper bits 0.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_code  in  2  code select, sampled on first beat of a frame: 00 -> m=6, n=63, poly x^6+x+1; 01 -> m=8, n=255, x^8+x^4+x^3+x^2+1; 10/11 -> m=10, n=1023, x^10+x^3+1.
- i_valid  in  1  LLR beat valid.
- i_llr  in  LLR_W  soft value of bit i; bits arrive in ascending index, i=0 first.
- o_flip_alpha_S1_1, _S3_1, _S5_1, _S7_1  out  GF_W each  alpha^(k*p1), k=1,3,5,7, for least-reliable position p1.
- o_flip_alpha_S1_2, _S3_2, _S5_2, _S7_2  out  GF_W each  same for second-least-reliable position p2.
- o_pos1, o_pos2  out  10  p1, p2.
- o_flip_alpha_valid  out  1  results stable.
- o_busy  out  1  frame in progress.

Behaviour:
- Reset: every output 0, all internal registers 0, state IDLE; a reset mid-frame discards the frame.
- States are IDLE, COLLECT and DONE.
  - IDLE or DONE + i_valid: beat is bit 0 of a new frame.
    - Latch code.
    - Beat counter <- 1.
    - Running powers r1, r3, r5, r7 restart at 1; bit 0 is evaluated with power 1.
    - Candidates are initialised to sentinel 128 before comparison.
    - Next state COLLECT; o_flip_alpha_valid drops the next cycle.
  - COLLECT: each i_valid beat processes bit i = counter; i_valid low stalls with all state held.
    - On the beat with i = n-1, go to DONE.
    - If n=1 beat were possible it would go straight to DONE; not applicable here.
  - DONE: o_flip_alpha_valid=1; outputs held until the next frame's first beat.
- o_busy = 1 in COLLECT only.
- Reliability: rel = |llr|, saturated so -128 -> 127; rel range is 0..127. Candidate reliability registers are 8 bits, so sentinel 128 is larger than any rel.
- Update rule per beat, strict compare (ties keep the earlier index):
  - If rel < c1: c2 <- c1 (with its stored position and powers), then c1 <- {rel, i, r1, r3, r5, r7}.
  - Else if rel < c2: c2 <- {rel, i, r1, r3, r5, r7}.
- Running powers: after each processed beat, r1 *= alpha, r3 *= alpha^3, r5 *= alpha^5, r7 *= alpha^7.
  - These are constant multipliers reduced modulo the latched polynomial.
  - Result bits >= m are 0.
- Outputs register from c1/c2 on the transition into DONE.
  - o_flip_alpha_valid rises exactly 1 cycle after bit n-1 is sampled.
  - S5/S7 outputs are forced to 0 when the latched code is 00 or 01.
- i_code changes mid-frame are ignored.
- Back-to-back frames: a first beat arriving the cycle after DONE is entered is accepted; no bubble is required.

Test Plan:
- Code 00; all LLR=100 except bit5=3, bit10=-7 -> 1 cycle after bit 62:
  - valid=1, pos1=5, pos2=10.
  - S1_1=0x020, S1_2=0x030, S3_1=0x028, S3_2=0x033.
  - S5/S7 outputs = 0.
- Code 00; all LLR=20 (ties) -> pos1=0, pos2=1, S1_1=0x001, S1_2=0x002, S3_2=0x008.
- Code 10; bit1022 LLR=0, bit0 LLR=1, others 50 -> pos1=1022, pos2=0, S1_1=0x204 (alpha^-1), S1_2=S3_2=S5_2=S7_2=0x001; valid 1 cycle after beat 1022.
- Code 01; all LLR=-128 except bit200=127 -> saturation gives equal magnitudes, so pos1=0, pos2=1; valid after 255 beats.
- Stall/reset: repeat the first scenario with random i_valid gaps -> identical outputs. Then assert i_rst at beat 30 of a frame -> all outputs 0 and IDLE. A fresh frame afterwards gives correct results.
- Back-to-back: a second code-00 frame starts the cycle after DONE -> valid drops next cycle, new pos values appear 1 cycle after its bit 62.

Source files
------------

// File: rtl/chase_flip_alpha_gen.sv
// ----------------------------------------------------------------------------
// chase_flip_alpha_gen
//
// Streaming front end of the Chase test-pattern path. Consumes one LLR per
// beat for a BCH codeword (bit 0 first) and tracks the two least-reliable
// positions p1 and p2. For each of them it produces alpha^p, alpha^3p,
// alpha^5p and alpha^7p in the GF(2^m) selected at the start of the frame.
// These results feed the flip-syndrome stage's flip-alpha inputs.
//
// Ports:
//   i_clk               clock
//   i_rst               synchronous active-high reset
//   i_code[1:0]         code select, sampled on the first beat of a frame
//                       00: m=6,  n=63,   x^6+x+1
//                       01: m=8,  n=255,  x^8+x^4+x^3+x^2+1
//                       1x: m=10, n=1023, x^10+x^3+1
//   i_valid             LLR beat valid
//   i_llr[LLR_W-1:0]    two's-complement soft value of the current bit
//   o_flip_alpha_Sk_1   alpha^(k*p1), k = 1,3,5,7 (S5/S7 are 0 for m=6/8)
//   o_flip_alpha_Sk_2   alpha^(k*p2), k = 1,3,5,7 (S5/S7 are 0 for m=6/8)
//   o_pos1, o_pos2      least / second-least reliable positions
//   o_flip_alpha_valid  results stable (DONE state)
//   o_busy              frame in progress (COLLECT state)
// ----------------------------------------------------------------------------
module chase_flip_alpha_gen #(
    parameter int LLR_W = 8,
    parameter int GF_W  = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_code,
    input  logic             i_valid,
    input  logic [LLR_W-1:0] i_llr,
    output logic [GF_W-1:0]  o_flip_alpha_S1_1,
    output logic [GF_W-1:0]  o_flip_alpha_S3_1,
    output logic [GF_W-1:0]  o_flip_alpha_S5_1,
    output logic [GF_W-1:0]  o_flip_alpha_S7_1,
    output logic [GF_W-1:0]  o_flip_alpha_S1_2,
    output logic [GF_W-1:0]  o_flip_alpha_S3_2,
    output logic [GF_W-1:0]  o_flip_alpha_S5_2,
    output logic [GF_W-1:0]  o_flip_alpha_S7_2,
    output logic [9:0]       o_pos1,
    output logic [9:0]       o_pos2,
    output logic             o_flip_alpha_valid,
    output logic             o_busy
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    localparam logic [GF_W-1:0] GF_ONE = {{(GF_W-1){1'b0}}, 1'b1};

    // One tracked candidate: reliability, position and the four powers
    // that were current when that position was seen.
    typedef struct packed {
        logic [7:0]      rel;
        logic [9:0]      pos;
        logic [GF_W-1:0] p1;
        logic [GF_W-1:0] p3;
        logic [GF_W-1:0] p5;
        logic [GF_W-1:0] p7;
    } cand_t;

    // Multiply a field element by alpha (= x), reducing by the code's polynomial.
    function automatic logic [GF_W-1:0] mul_x(input logic [GF_W-1:0] a,
                                              input logic [1:0]      code);
        logic [GF_W-1:0] t;
        t = '0;
        case (code)
            2'b00:   t[5:0] = {a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00);
            2'b01:   t[7:0] = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
            default: t[9:0] = {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
        endcase
        return t;
    endfunction

    // Multiply by alpha^k for a small constant k (at most 7).
    function automatic logic [GF_W-1:0] mul_xk(input logic [GF_W-1:0] a,
                                               input logic [1:0]      code,
                                               input int              k);
        logic [GF_W-1:0] t;
        t = a;
        for (int i = 0; i < 7; i++) begin
            t = (i < k) ? mul_x(t, code) : t;
        end
        return t;
    endfunction

    // Index of the final bit of a codeword (n-1).
    function automatic logic [9:0] last_idx(input logic [1:0] code);
        logic [9:0] r;
        case (code)
            2'b00:   r = 10'd62;
            2'b01:   r = 10'd254;
            default: r = 10'd1022;
        endcase
        return r;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      code_r;
    logic [9:0]      cnt_r;
    logic [GF_W-1:0] pw1_r, pw3_r, pw5_r, pw7_r;
    cand_t           c1_r, c2_r;

    logic            first_s;
    logic            beat_s;
    logic            last_s;
    logic [1:0]      code_s;
    logic [LLR_W-1:0] mag_s;
    logic [7:0]      rel_s;
    cand_t           sent_s, base1_s, base2_s, new_s, c1_nxt_s, c2_nxt_s;
    logic [GF_W-1:0] pw1_nxt_s, pw3_nxt_s, pw5_nxt_s, pw7_nxt_s;

    // Beat classification: a valid beat outside COLLECT is bit 0 of a new frame.
    always_comb begin
        first_s = i_valid && (state_r != ST_COLLECT);
        beat_s  = i_valid && (state_r == ST_COLLECT);
        code_s  = first_s ? i_code : code_r;
        last_s  = beat_s && (cnt_r == last_idx(code_r));
    end

    // Saturated magnitude: the most negative LLR maps to 127.
    always_comb begin
        if (i_llr[LLR_W-1]) begin
            mag_s = -i_llr;
        end else begin
            mag_s = i_llr;
        end
        if (mag_s > LLR_W'(8'd127)) begin
            rel_s = 8'd127;
        end else begin
            rel_s = mag_s[7:0];
        end
    end

    // Candidate update for the current beat; a new frame starts from sentinels
    // and unit powers so bit 0 goes through the same compare path.
    always_comb begin
        sent_s     = '0;
        sent_s.rel = 8'd128;
        if (first_s) begin
            base1_s   = sent_s;
            base2_s   = sent_s;
            new_s.pos = 10'd0;
            new_s.p1  = GF_ONE;
            new_s.p3  = GF_ONE;
            new_s.p5  = GF_ONE;
            new_s.p7  = GF_ONE;
        end else begin
            base1_s   = c1_r;
            base2_s   = c2_r;
            new_s.pos = cnt_r;
            new_s.p1  = pw1_r;
            new_s.p3  = pw3_r;
            new_s.p5  = pw5_r;
            new_s.p7  = pw7_r;
        end
        new_s.rel = rel_s;

        // Strict compares: on ties the earlier index stays in place.
        if (new_s.rel < base1_s.rel) begin
            c1_nxt_s = new_s;
            c2_nxt_s = base1_s;
        end else if (new_s.rel < base2_s.rel) begin
            c1_nxt_s = base1_s;
            c2_nxt_s = new_s;
        end else begin
            c1_nxt_s = base1_s;
            c2_nxt_s = base2_s;
        end

        pw1_nxt_s = mul_xk(new_s.p1, code_s, 1);
        pw3_nxt_s = mul_xk(new_s.p3, code_s, 3);
        pw5_nxt_s = mul_xk(new_s.p5, code_s, 5);
        pw7_nxt_s = mul_xk(new_s.p7, code_s, 7);
    end

    // Frame FSM, running powers, candidates and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r            <= ST_IDLE;
            code_r             <= 2'b00;
            cnt_r              <= 10'd0;
            pw1_r              <= '0;
            pw3_r              <= '0;
            pw5_r              <= '0;
            pw7_r              <= '0;
            c1_r               <= '0;
            c2_r               <= '0;
            o_flip_alpha_S1_1  <= '0;
            o_flip_alpha_S3_1  <= '0;
            o_flip_alpha_S5_1  <= '0;
            o_flip_alpha_S7_1  <= '0;
            o_flip_alpha_S1_2  <= '0;
            o_flip_alpha_S3_2  <= '0;
            o_flip_alpha_S5_2  <= '0;
            o_flip_alpha_S7_2  <= '0;
            o_pos1             <= 10'd0;
            o_pos2             <= 10'd0;
            o_flip_alpha_valid <= 1'b0;
            o_busy             <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (first_s) begin
                        code_r             <= i_code;
                        cnt_r              <= 10'd1;
                        pw1_r              <= pw1_nxt_s;
                        pw3_r              <= pw3_nxt_s;
                        pw5_r              <= pw5_nxt_s;
                        pw7_r              <= pw7_nxt_s;
                        c1_r               <= c1_nxt_s;
                        c2_r               <= c2_nxt_s;
                        o_flip_alpha_valid <= 1'b0;
                        o_busy             <= 1'b1;
                        state_r            <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (beat_s) begin
                        cnt_r <= cnt_r + 10'd1;
                        pw1_r <= pw1_nxt_s;
                        pw3_r <= pw3_nxt_s;
                        pw5_r <= pw5_nxt_s;
                        pw7_r <= pw7_nxt_s;
                        c1_r  <= c1_nxt_s;
                        c2_r  <= c2_nxt_s;
                        if (last_s) begin
                            state_r            <= ST_DONE;
                            o_busy             <= 1'b0;
                            o_flip_alpha_valid <= 1'b1;
                            o_pos1             <= c1_nxt_s.pos;
                            o_pos2             <= c2_nxt_s.pos;
                            o_flip_alpha_S1_1  <= c1_nxt_s.p1;
                            o_flip_alpha_S3_1  <= c1_nxt_s.p3;
                            o_flip_alpha_S1_2  <= c2_nxt_s.p1;
                            o_flip_alpha_S3_2  <= c2_nxt_s.p3;
                            // Only the m=10 code carries S5/S7 downstream.
                            o_flip_alpha_S5_1  <= code_r[1] ? c1_nxt_s.p5 : '0;
                            o_flip_alpha_S7_1  <= code_r[1] ? c1_nxt_s.p7 : '0;
                            o_flip_alpha_S5_2  <= code_r[1] ? c2_nxt_s.p5 : '0;
                            o_flip_alpha_S7_2  <= code_r[1] ? c2_nxt_s.p7 : '0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chase_flip_alpha_gen.sv
module tb_chase_flip_alpha_gen;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_code;
    logic       i_valid;
    logic [7:0] i_llr;
    logic [9:0] s1_1, s3_1, s5_1, s7_1, s1_2, s3_2, s5_2, s7_2;
    logic [9:0] pos1, pos2;
    logic       fa_valid, busy;

    always #5 i_clk = ~i_clk;

    chase_flip_alpha_gen #(.LLR_W(8), .GF_W(10)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_code             (i_code),
        .i_valid            (i_valid),
        .i_llr              (i_llr),
        .o_flip_alpha_S1_1  (s1_1),
        .o_flip_alpha_S3_1  (s3_1),
        .o_flip_alpha_S5_1  (s5_1),
        .o_flip_alpha_S7_1  (s7_1),
        .o_flip_alpha_S1_2  (s1_2),
        .o_flip_alpha_S3_2  (s3_2),
        .o_flip_alpha_S5_2  (s5_2),
        .o_flip_alpha_S7_2  (s7_2),
        .o_pos1             (pos1),
        .o_pos2             (pos2),
        .o_flip_alpha_valid (fa_valid),
        .o_busy             (busy)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [7:0] llr_q [1023];
    int                exp_tab [3][1023];

    typedef struct {
        logic [1:0] code;
        int base; int ia; int va; int ib; int vb;
        int pos1; int pos2;
        int s1_1; int s1_2; int s3_1; int s3_2; int s5_2; int s7_2;
    } vec_t;
    vec_t vecs [4];

    function automatic int n_of(input logic [1:0] c);
        return (c == 2'b00) ? 63 : (c == 2'b01) ? 255 : 1023;
    endfunction

    function automatic int tix(input logic [1:0] c);
        return (c == 2'b00) ? 0 : (c == 2'b01) ? 1 : 2;
    endfunction

    function automatic int rel_of(input logic signed [7:0] v);
        int x;
        x = v;
        if (x < 0) x = -x;
        if (x > 127) x = 127;
        return x;
    endfunction

    // alpha^(k*p) from an antilog table built by polynomial arithmetic
    function automatic int apow(input logic [1:0] c, input int k, input int p);
        return exp_tab[tix(c)][(k * p) % n_of(c)];
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    task automatic build_tables();
        int m, poly, v, n;
        for (int c = 0; c < 3; c++) begin
            m    = (c == 0) ? 6 : (c == 1) ? 8 : 10;
            poly = (c == 0) ? 'h43 : (c == 1) ? 'h11D : 'h409;
            n    = (1 << m) - 1;
            v    = 1;
            for (int e = 0; e < n; e++) begin
                exp_tab[c][e] = v;
                v = v << 1;
                if (((v >> m) & 1) != 0) v = v ^ poly;
            end
        end
    endtask

    task automatic fill_llr(input vec_t v);
        for (int i = 0; i < n_of(v.code); i++) llr_q[i] = 8'(v.base);
        llr_q[v.ia] = 8'(v.va);
        llr_q[v.ib] = 8'(v.vb);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".s1_1"}, s1_1, 0); check({tag, ".s3_1"}, s3_1, 0);
        check({tag, ".s5_1"}, s5_1, 0); check({tag, ".s7_1"}, s7_1, 0);
        check({tag, ".s1_2"}, s1_2, 0); check({tag, ".s3_2"}, s3_2, 0);
        check({tag, ".s5_2"}, s5_2, 0); check({tag, ".s7_2"}, s7_2, 0);
        check({tag, ".pos1"}, pos1, 0); check({tag, ".pos2"}, pos2, 0);
        check({tag, ".valid"}, fa_valid, 0); check({tag, ".busy"}, busy, 0);
    endtask

    // Reference: stable two-smallest selection over the whole frame.
    task automatic check_model(input string tag, input logic [1:0] c);
        int p1, p2, n;
        n  = n_of(c);
        p1 = -1;
        p2 = -1;
        for (int i = 0; i < n; i++)
            if (p1 < 0 || rel_of(llr_q[i]) < rel_of(llr_q[p1])) p1 = i;
        for (int i = 0; i < n; i++)
            if (i != p1 && (p2 < 0 || rel_of(llr_q[i]) < rel_of(llr_q[p2]))) p2 = i;
        check({tag, ".valid"}, fa_valid, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".pos1"}, pos1, p1);
        check({tag, ".pos2"}, pos2, p2);
        check({tag, ".s1_1"}, s1_1, apow(c, 1, p1));
        check({tag, ".s3_1"}, s3_1, apow(c, 3, p1));
        check({tag, ".s5_1"}, s5_1, c[1] ? apow(c, 5, p1) : 0);
        check({tag, ".s7_1"}, s7_1, c[1] ? apow(c, 7, p1) : 0);
        check({tag, ".s1_2"}, s1_2, apow(c, 1, p2));
        check({tag, ".s3_2"}, s3_2, apow(c, 3, p2));
        check({tag, ".s5_2"}, s5_2, c[1] ? apow(c, 5, p2) : 0);
        check({tag, ".s7_2"}, s7_2, c[1] ? apow(c, 7, p2) : 0);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".tpos1"}, pos1, v.pos1);
        check({tag, ".tpos2"}, pos2, v.pos2);
        check({tag, ".ts1_1"}, s1_1, v.s1_1);
        check({tag, ".ts1_2"}, s1_2, v.s1_2);
        check({tag, ".ts3_1"}, s3_1, v.s3_1);
        check({tag, ".ts3_2"}, s3_2, v.s3_2);
        check({tag, ".ts5_2"}, s5_2, v.s5_2);
        check({tag, ".ts7_2"}, s7_2, v.s7_2);
    endtask

    // Starts and ends on a falling edge. On return the last beat has just been
    // sampled and i_valid is still high: the caller must drive next cycle's
    // inputs before advancing time.
    task automatic send_frame(input string tag, input logic [1:0] c,
                              input int gap_pct, input int nbeats);
        int n;
        n = n_of(c);
        for (int i = 0; i < nbeats; i++) begin
            if (i == 1) begin
                check({tag, ".valid_drop"}, fa_valid, 0);
                check({tag, ".busy_rise"}, busy, 1);
            end
            if (i == n - 1) check({tag, ".valid_early"}, fa_valid, 0);
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_valid = 1'b0;
                i_llr   = 8'($urandom);
                @(negedge i_clk);
            end
            i_valid = 1'b1;
            i_llr   = llr_q[i];
            i_code  = (i == 0) ? c : 2'($urandom);
            @(negedge i_clk);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_llr   = 8'd0;
        i_code  = 2'b00;
        build_tables();
        vecs[0] = '{2'b00, 100, 5, 3, 10, -7, 5, 10,
                    'h020, 'h030, 'h028, 'h033, 'h000, 'h000};
        vecs[1] = '{2'b00, 20, 0, 20, 1, 20, 0, 1,
                    'h001, 'h002, 'h001, 'h008, 'h000, 'h000};
        vecs[2] = '{2'b10, 50, 1022, 0, 0, 1, 1022, 0,
                    'h204, 'h001, 'h081, 'h001, 'h001, 'h001};
        vecs[3] = '{2'b01, -128, 200, 127, 0, -128, 0, 1,
                    'h001, 'h002, 'h001, 'h008, 'h000, 'h000};

        repeat (3) @(negedge i_clk);
        check_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_zero("idle");

        // Directed table
        for (int v = 0; v < 4; v++) begin
            fill_llr(vecs[v]);
            send_frame($sformatf("vec%0d", v), vecs[v].code, 0, n_of(vecs[v].code));
            i_valid = 1'b0;
            check_vec($sformatf("vec%0d", v), vecs[v]);
            check_model($sformatf("vec%0d", v), vecs[v].code);
            @(negedge i_clk);
            check($sformatf("vec%0d.hold", v), fa_valid, 1);
        end

        // Stalls must not change the result
        fill_llr(vecs[0]);
        send_frame("stall", 2'b00, 35, 63);
        i_valid = 1'b0;
        check_vec("stall", vecs[0]);
        check_model("stall", 2'b00);

        // Reset in the middle of a frame
        send_frame("midrst", 2'b00, 0, 30);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_zero("midrst");
        @(negedge i_clk);
        check({"midrst", ".busy_idle"}, busy, 0);
        fill_llr(vecs[1]);
        send_frame("fresh", 2'b00, 0, 63);
        i_valid = 1'b0;
        check_vec("fresh", vecs[1]);
        check_model("fresh", 2'b00);
        @(negedge i_clk);

        // Back-to-back frames without a bubble
        fill_llr(vecs[0]);
        send_frame("b2b_a", 2'b00, 0, 63);
        check_vec("b2b_a", vecs[0]);
        check_model("b2b_a", 2'b00);
        fill_llr(vecs[1]);
        send_frame("b2b_b", 2'b00, 0, 63);
        i_valid = 1'b0;
        check_vec("b2b_b", vecs[1]);
        check_model("b2b_b", 2'b00);
        @(negedge i_clk);

        // Randomized frames against the reference model
        for (int r = 0; r < 6; r++) begin
            logic [1:0] c;
            c = 2'($urandom_range(3));
            for (int i = 0; i < n_of(c); i++) begin
                if (r % 2 == 1) llr_q[i] = 8'(int'($urandom_range(15)) - 8);
                else            llr_q[i] = 8'($urandom);
            end
            send_frame($sformatf("rand%0d", r), c, 20, n_of(c));
            i_valid = 1'b0;
            check_model($sformatf("rand%0d", r), c);
            @(negedge i_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
